// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 32-bit timer with prescaler, compare match,
// auto-reload, one-shot and a scratch register, in an 8-word window at BASE.
// Offsets: 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS (W1C), 4 PRESCALE, 5 SCRATCH.
// Optional interrupt output o_irq is built when TIMER_IRQ_EN is defined.
module mmio_timer #(
  parameter int unsigned     SIZE = 14,
  parameter logic [SIZE-1:0] BASE = 14'h3FF0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [SIZE-1:0] i_addr,
  input  logic [31:0]     i_ram_data_in,
  output logic [31:0]     o_ram_data_out
`ifdef TIMER_IRQ_EN
  ,
  output logic            o_irq
`endif
);

`ifdef TIMER_IRQ_EN
  localparam logic [3:0] CTRL_WMASK = 4'hF;
`else
  localparam logic [3:0] CTRL_WMASK = 4'h7;
`endif

  logic [3:0]  r_ctrl;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_status;
  logic [15:0] r_prescale;
  logic [31:0] r_scratch;
  logic [15:0] r_pcnt;
  logic [31:0] r_rdata;

  logic        w_hit;
  logic [2:0]  w_off;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_wr_prescale;
  logic        w_wr_scratch;
  logic        w_tick;
  logic        w_match;
  logic [31:0] w_rd;

  assign w_hit         = (i_addr[SIZE-1:3] == BASE[SIZE-1:3]);
  assign w_off         = i_addr[2:0];
  assign w_wr          = i_we && w_hit;
  assign w_wr_ctrl     = w_wr && (w_off == 3'd0);
  assign w_wr_count    = w_wr && (w_off == 3'd1);
  assign w_wr_compare  = w_wr && (w_off == 3'd2);
  assign w_wr_status   = w_wr && (w_off == 3'd3);
  assign w_wr_prescale = w_wr && (w_off == 3'd4);
  assign w_wr_scratch  = w_wr && (w_off == 3'd5);

  assign w_tick  = r_ctrl[0] && (r_pcnt == r_prescale);
  assign w_match = w_tick && (r_count == r_compare);

  // Read mux over the pre-edge register values (read-before-write)
  always_comb begin
    w_rd = '0;
    if (w_hit) begin
      case (w_off)
        3'd0:    w_rd = {28'd0, r_ctrl};
        3'd1:    w_rd = r_count;
        3'd2:    w_rd = r_compare;
        3'd3:    w_rd = {31'd0, r_status};
        3'd4:    w_rd = {16'd0, r_prescale};
        3'd5:    w_rd = r_scratch;
        default: w_rd = '0;
      endcase
    end
  end

  // Registered read data, updated every cycle regardless of i_we
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rdata <= '0;
    else     r_rdata <= w_rd;
  end

  assign o_ram_data_out = r_rdata;

  // Prescaler: free-runs while enabled, cleared by a CTRL write that disables
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (w_wr_ctrl && !i_ram_data_in[0]) begin
      r_pcnt <= '0;
    end else if (r_ctrl[0]) begin
      r_pcnt <= w_tick ? '0 : r_pcnt + 16'd1;
    end
  end

  // CTRL: CPU write wins over the one-shot enable clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl <= '0;
    end else if (w_wr_ctrl) begin
      r_ctrl <= i_ram_data_in[3:0] & CTRL_WMASK;
    end else if (w_match && r_ctrl[2]) begin
      r_ctrl <= r_ctrl & 4'b1110;
    end
  end

  // COUNT: CPU write wins over the tick update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_wr_count) begin
      r_count <= i_ram_data_in;
    end else if (w_tick) begin
      r_count <= (w_match && r_ctrl[1]) ? '0 : r_count + 32'd1;
    end
  end

  // STATUS match flag: set on match, W1C, set has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= 1'b0;
    end else if (w_match) begin
      r_status <= 1'b1;
    end else if (w_wr_status && i_ram_data_in[0]) begin
      r_status <= 1'b0;
    end
  end

  // Plain CPU-written registers: COMPARE, PRESCALE, SCRATCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_compare  <= '0;
      r_prescale <= '0;
      r_scratch  <= '0;
    end else begin
      if (w_wr_compare)  r_compare  <= i_ram_data_in;
      if (w_wr_prescale) r_prescale <= i_ram_data_in[15:0];
      if (w_wr_scratch)  r_scratch  <= i_ram_data_in;
    end
  end

`ifdef TIMER_IRQ_EN
  logic r_irq;

  // Interrupt level follows the match flag gated by CTRL.b3, one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= r_status & r_ctrl[3];
  end

  assign o_irq = r_irq;
`endif

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed bench for mmio_timer with a register-array model
// checked against the read data (and o_irq when TIMER_IRQ_EN) every cycle.
module tb_mmio_timer;
  localparam int unsigned SIZE = 14;
  localparam logic [13:0] BASE = 14'h3FF0;
  localparam logic [13:0] IDLE = 14'h3FF1;   // park the bus on COUNT

`ifdef TIMER_IRQ_EN
  localparam logic [31:0] CTRL8_RB = 32'd8;
`else
  localparam logic [31:0] CTRL8_RB = 32'd0;
`endif

  logic        clk;
  logic        rst;
  logic        i_we;
  logic [13:0] i_addr;
  logic [31:0] i_ram_data_in;
  logic [31:0] o_ram_data_out;
`ifdef TIMER_IRQ_EN
  logic        o_irq;
`endif

  int checks = 0;
  int errors = 0;

  mmio_timer #(.SIZE(SIZE), .BASE(BASE)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_we           (i_we),
    .i_addr         (i_addr),
    .i_ram_data_in  (i_ram_data_in),
    .o_ram_data_out (o_ram_data_out)
`ifdef TIMER_IRQ_EN
    ,
    .o_irq          (o_irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_reg [8];
  logic [31:0] m_old [8];
  logic [15:0] m_pcnt;
  logic [31:0] m_rdata;
  logic        m_irq;
  logic        m_hit, m_tick, m_match;
  logic [2:0]  m_off;

  function automatic logic [31:0] wmask(input logic [2:0] off);
    case (off)
      3'd0:    return 32'(CTRL8_RB[3:0] | 4'h7);
      3'd4:    return 32'h0000FFFF;
      3'd6,
      3'd7:    return 32'h0;
      default: return 32'hFFFFFFFF;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      foreach (m_reg[k]) m_reg[k] = '0;
      m_pcnt = '0; m_rdata = '0; m_irq = 1'b0;
    end else begin
      m_hit   = (i_addr[13:3] == BASE[13:3]);
      m_off   = i_addr[2:0];
      m_old   = m_reg;
      m_rdata = m_hit ? m_old[m_off] : 32'd0;
      m_irq   = m_old[3][0] & m_old[0][3];
      m_tick  = m_old[0][0] && (m_pcnt == m_old[4][15:0]);
      m_match = m_tick && (m_old[1] == m_old[2]);
      if (m_old[0][0]) m_pcnt = m_tick ? 16'd0 : m_pcnt + 16'd1;
      if (m_tick) m_reg[1] = (m_match && m_old[0][1]) ? 32'd0 : m_old[1] + 32'd1;
      if (m_match) begin
        m_reg[3] = 32'd1;
        if (m_old[0][2]) m_reg[0][0] = 1'b0;
      end
      if (i_we && m_hit) begin
        if (m_off == 3'd3) begin
          if (i_ram_data_in[0] && !m_match) m_reg[3] = 32'd0;
        end else begin
          m_reg[m_off] = i_ram_data_in & wmask(m_off);
        end
        if (m_off == 3'd0 && !i_ram_data_in[0]) m_pcnt = 16'd0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("model_rdata", o_ram_data_out, m_rdata);
`ifdef TIMER_IRQ_EN
      chk("model_irq", {31'd0, o_irq}, {31'd0, m_irq});
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    i_we = 1'b1; i_addr = {BASE[13:3], off}; i_ram_data_in = d;
    cyc();
    i_we = 1'b0; i_addr = IDLE; i_ram_data_in = '0;
  endtask

  task automatic rdchk_a(input logic [13:0] a, input string name, input logic [31:0] exp);
    i_we = 1'b0; i_addr = a;
    cyc();
    chk(name, o_ram_data_out, exp);
    i_addr = IDLE;
  endtask

  task automatic rdchk(input logic [2:0] off, input string name, input logic [31:0] exp);
    rdchk_a({BASE[13:3], off}, name, exp);
  endtask

  initial begin
    rst = 1'b1; i_we = 1'b0; i_addr = IDLE; i_ram_data_in = '0;
    #1 chk("reset_rdata", o_ram_data_out, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values and basic register access
    for (int i = 0; i < 6; i++) rdchk(3'(i), "reset_reg", 32'd0);
    wr(3'd5, 32'hDEADBEEF);
    rdchk(3'd5, "scratch", 32'hDEADBEEF);
    rdchk_a(BASE - 14'd1, "base_minus_1", 32'd0);
    wr(3'd6, 32'hFFFFFFFF);
    rdchk(3'd6, "off6", 32'd0);
    rdchk(3'd7, "off7", 32'd0);
    wr(3'd0, 32'd8);
    rdchk(3'd0, "ctrl_b3", CTRL8_RB);
    wr(3'd0, 32'd0);
    wr(3'd4, 32'hFFFF1234);
    rdchk(3'd4, "prescale_narrow", 32'h00001234);
    wr(3'd3, 32'hFFFFFFFF);
    rdchk(3'd3, "status_w1_noset", 32'd0);

    // Prescale 3: tick every 4 cycles, match at COUNT=100
    wr(3'd4, 32'd3);
    wr(3'd2, 32'd100);
    wr(3'd0, 32'd1);
    repeat (402) cyc();
    rdchk(3'd1, "ps_count100", 32'd100);
    rdchk(3'd3, "ps_status_pre", 32'd0);
    rdchk(3'd1, "ps_count101", 32'd101);
    rdchk(3'd3, "ps_status_set", 32'd1);
    wr(3'd0, 32'd0);
    wr(3'd3, 32'd1);

    // Auto-reload 0..5 with W1C colliding with a match
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd5);
    wr(3'd4, 32'd0);
    wr(3'd3, 32'd1);
    wr(3'd0, 32'd3);
    repeat (7) cyc();
    wr(3'd3, 32'd1);
    rdchk(3'd3, "ar_w1c", 32'd0);
    repeat (2) cyc();
    wr(3'd3, 32'd1);
    rdchk(3'd3, "ar_match_beats_w1c", 32'd1);
    rdchk(3'd1, "ar_wrapped", 32'd1);
    wr(3'd0, 32'd0);

    // 32-bit wrap without flag
    wr(3'd2, 32'd7);
    wr(3'd3, 32'd1);
    wr(3'd1, 32'hFFFFFFFF);
    wr(3'd0, 32'd1);
    rdchk(3'd1, "wrap_pre", 32'hFFFFFFFF);
    rdchk(3'd1, "wrap_zero", 32'd0);
    rdchk(3'd3, "wrap_noflag", 32'd0);
    wr(3'd0, 32'd0);

    // One-shot stops after match
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd2);
    wr(3'd0, 32'd5);
    repeat (5) cyc();
    rdchk(3'd0, "os_ctrl", 32'd4);
    rdchk(3'd1, "os_count", 32'd3);
    rdchk(3'd3, "os_status", 32'd1);
    wr(3'd3, 32'd1);

    // CPU COUNT write on a tick cycle, then async reset mid-count
    wr(3'd2, 32'd1000);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd1);
    repeat (3) cyc();
    wr(3'd1, 32'd50);
    rdchk(3'd1, "count_wr_wins", 32'd50);
    repeat (4) cyc();
    #2 rst = 1'b1;
    #1 chk("async_rst_rdata", o_ram_data_out, 32'd0);
`ifdef TIMER_IRQ_EN
    chk("async_rst_irq", {31'd0, o_irq}, 32'd0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) rdchk(3'(i), "post_rst_reg", 32'd0);

`ifdef TIMER_IRQ_EN
    // Interrupt follows STATUS by one cycle, drops one cycle after W1C
    wr(3'd2, 32'd2);
    wr(3'd0, 32'd9);
    repeat (3) cyc();
    chk("irq_pre", {31'd0, o_irq}, 32'd0);
    cyc();
    chk("irq_set", {31'd0, o_irq}, 32'd1);
    wr(3'd3, 32'd1);
    chk("irq_hold", {31'd0, o_irq}, 32'd1);
    cyc();
    chk("irq_clr", {31'd0, o_irq}, 32'd0);
`endif

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
